fuel_gauge_ctrl: RTL and testbench

- Sequencer for the two-digit BCD fuel counter. Turns game speed into timed burn (decrement) pulses.
- Queues fuel pickups and drains them as one-unit refuel (increment) pulses, giving a visible "inflating" gauge.
- Raises low-fuel warning/blink and a latched empty flag.
- Sits between game control (speed, pickup collision) and the fuel counter, which it reads back via units/tens.

---
 rtl/fuel_gauge_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fuel_gauge_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fuel_gauge_ctrl.sv
// Fuel gauge sequencer: turns game speed into timed burn pulses, drains queued
// pickups as one-unit refuel pulses, and raises low-fuel / blink / empty flags.
module fuel_gauge_ctrl #(
    parameter int unsigned PERIOD_S1    = 60,
    parameter int unsigned PERIOD_S2    = 40,
    parameter int unsigned PERIOD_S3    = 20,
    parameter int unsigned REFUEL_UNITS = 20,
    parameter int unsigned MAX_PENDING  = 60,
    parameter int unsigned LOW_THRESH   = 10,
    parameter int unsigned BLINK_HALF   = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [1:0] speed,
    input  logic       fuel_pickup,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    output logic       dec_pulse,
    output logic       inc_pulse,
    output logic       refueling,
    output logic       low_fuel,
    output logic       warn_blink,
    output logic       empty
);

    localparam int BLINK_W = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {IDLE, BURN, REFUEL, EMPTY} state_t;

    state_t             state_q, state_d;
    logic [6:0]         burn_cnt_q, burn_cnt_d;
    logic [6:0]         pending_q, pending_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               dec_q, dec_d;
    logic               inc_q, inc_d;
    logic               refueling_q, refueling_d;
    logic               low_fuel_q, low_fuel_d;
    logic               warn_q, warn_d;
    logic               empty_q, empty_d;

    logic [6:0] fuel;
    logic       fuel_zero;
    logic       fuel_full;
    logic       burn_active;
    logic       refuel_active;
    logic       pickup_ok;
    logic       clear_pending;
    logic [7:0] pend_sum;

    assign fuel      = ({3'b000, tens} * 7'd10) + {3'b000, units};
    assign fuel_zero = (units == 4'd0) && (tens == 4'd0);
    assign fuel_full = (fuel == 7'd99);

    function automatic logic [6:0] burn_period(input logic [1:0] spd);
        case (spd)
            2'd1:    burn_period = 7'(PERIOD_S1);
            2'd2:    burn_period = 7'(PERIOD_S2);
            default: burn_period = 7'(PERIOD_S3);
        endcase
    endfunction

    // Burning stops as soon as a refuel is queued or the tank reads empty, so a
    // decrement can never race an increment or underflow the counter.
    assign burn_active   = (state_q == BURN) && enable && (pending_q == 7'd0) && !fuel_zero;
    assign refuel_active = (state_q == REFUEL) && enable && (pending_q != 7'd0);
    assign pickup_ok     = fuel_pickup && (state_q != EMPTY);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d       = state_q;
        burn_cnt_d    = burn_cnt_q;
        dec_d         = 1'b0;
        inc_d         = 1'b0;
        clear_pending = 1'b0;

        if (burn_active && frame_tick && (speed != 2'd0)) begin
            if (burn_cnt_q >= burn_period(speed) - 7'd1) begin
                dec_d      = 1'b1;
                burn_cnt_d = 7'd0;
            end else begin
                burn_cnt_d = burn_cnt_q + 7'd1;
            end
        end

        if (refuel_active && frame_tick) begin
            if (fuel_full) clear_pending = 1'b1;
            else           inc_d         = 1'b1;
        end

        pend_sum = {1'b0, pending_q}
                 + (pickup_ok ? 8'(REFUEL_UNITS) : 8'd0)
                 - (inc_d ? 8'd1 : 8'd0);
        if (clear_pending)                   pending_d = 7'd0;
        else if (pend_sum > 8'(MAX_PENDING)) pending_d = 7'(MAX_PENDING);
        else                                 pending_d = pend_sum[6:0];

        case (state_q)
            IDLE:   if (enable) state_d = (pending_q != 7'd0) ? REFUEL : BURN;
            BURN: begin
                if (!enable)                 state_d = IDLE;
                else if (pending_q != 7'd0)  state_d = REFUEL;
                else if (fuel_zero)          state_d = EMPTY;
            end
            REFUEL: begin
                if (!enable)                 state_d = IDLE;
                else if (pending_q == 7'd0)  state_d = BURN;
            end
            default:                         state_d = EMPTY;
        endcase

        refueling_d = (state_d == REFUEL);
        empty_d     = (state_d == EMPTY);
        low_fuel_d  = !fuel_zero && (fuel < 7'(LOW_THRESH)) && (state_d != EMPTY);

        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!low_fuel_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
        warn_d = low_fuel_d && phase_d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            burn_cnt_q  <= '0;
            pending_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            dec_q       <= 1'b0;
            inc_q       <= 1'b0;
            refueling_q <= 1'b0;
            low_fuel_q  <= 1'b0;
            warn_q      <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            burn_cnt_q  <= burn_cnt_d;
            pending_q   <= pending_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            dec_q       <= dec_d;
            inc_q       <= inc_d;
            refueling_q <= refueling_d;
            low_fuel_q  <= low_fuel_d;
            warn_q      <= warn_d;
            empty_q     <= empty_d;
        end
    end

    assign dec_pulse  = dec_q;
    assign inc_pulse  = inc_q;
    assign refueling  = refueling_q;
    assign low_fuel   = low_fuel_q;
    assign warn_blink = warn_q;
    assign empty      = empty_q;

endmodule

// File: tb/tb_fuel_gauge_ctrl.sv
// Directed bench for fuel_gauge_ctrl: expected pulses per frame are queued on
// stimulus and popped when the DUT output is sampled; the bench models the fuel counter.
module tb_fuel_gauge_ctrl;

    logic       clk = 1'b0;
    logic       resetN;
    logic       enable;
    logic       frame_tick;
    logic [1:0] speed;
    logic       fuel_pickup;
    logic [3:0] units;
    logic [3:0] tens;
    logic       dec_pulse;
    logic       inc_pulse;
    logic       refueling;
    logic       low_fuel;
    logic       warn_blink;
    logic       empty;

    int checks   = 0;
    int failures = 0;
    int fuel     = 0;

    typedef struct {
        string      tag;
        logic [1:0] pulses;
    } exp_t;

    exp_t sb[$];

    fuel_gauge_ctrl dut (
        .clk        (clk),
        .resetN     (resetN),
        .enable     (enable),
        .frame_tick (frame_tick),
        .speed      (speed),
        .fuel_pickup(fuel_pickup),
        .units      (units),
        .tens       (tens),
        .dec_pulse  (dec_pulse),
        .inc_pulse  (inc_pulse),
        .refueling  (refueling),
        .low_fuel   (low_fuel),
        .warn_blink (warn_blink),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fuel(input int f);
        fuel  = f;
        units = 4'(f % 10);
        tens  = 4'(f / 10);
    endtask

    // One frame: queue the expected pulse pair, issue the tick, compare the cycle
    // after, then confirm the pulse has gone in the following two cycles.
    task automatic frame(input string tag, input bit exp_dec, input bit exp_inc);
        exp_t e;
        e.tag    = tag;
        e.pulses = {exp_dec, exp_inc};
        sb.push_back(e);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, 32'({dec_pulse, inc_pulse}), 32'(e.pulses));
        end
        if (dec_pulse && fuel > 0)       drive_fuel(fuel - 1);
        else if (inc_pulse && fuel < 99) drive_fuel(fuel + 1);
        repeat (2) begin
            @(negedge clk);
            check({tag, "_gap"}, 32'({dec_pulse, inc_pulse}), 32'd0);
        end
    endtask

    task automatic pickup();
        @(negedge clk) fuel_pickup = 1'b1;
        @(negedge clk) fuel_pickup = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({dec_pulse, inc_pulse, refueling, low_fuel, warn_blink, empty});
    endfunction

    initial begin
        resetN      = 1'b0;
        enable      = 1'b0;
        frame_tick  = 1'b0;
        speed       = 2'd0;
        fuel_pickup = 1'b0;
        drive_fuel(50);
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 32'd0);
        resetN = 1'b1;
        @(negedge clk);
        check("idle_outs", all_outs(), 32'd0);

        // Speed 3: burns after ticks 20, 40, 60 only.
        enable = 1'b1;
        speed  = 2'd3;
        for (int k = 1; k <= 60; k++) frame("t1_burn_s3", (k % 20) == 0, 1'b0);

        // Speed 1 for 30 ticks, then speed 3 fires at once on the stale count.
        speed = 2'd1;
        for (int k = 1; k <= 30; k++) frame("t2_burn_s1", 1'b0, 1'b0);
        speed = 2'd3;
        frame("t2_switch_fire", 1'b1, 1'b0);
        for (int k = 1; k <= 40; k++) frame("t2_burn_after", (k % 20) == 0, 1'b0);

        // One pickup at fuel 40 with burn count at 5: 20 incs, then burn resumes.
        for (int k = 1; k <= 5; k++) frame("t3_preburn", 1'b0, 1'b0);
        drive_fuel(40);
        pickup();
        check("t3_refueling_on", 32'(refueling), 32'd1);
        for (int k = 1; k <= 20; k++) frame("t3_inc", 1'b0, 1'b1);
        check("t3_refueling_off", 32'(refueling), 32'd0);
        for (int k = 1; k <= 15; k++) frame("t3_resume", k == 15, 1'b0);

        // Four pickups saturate the queue at 60; then a top-up stops at 99.
        speed = 2'd0;
        drive_fuel(30);
        repeat (4) pickup();
        check("t4_refueling_on", 32'(refueling), 32'd1);
        for (int k = 1; k <= 60; k++) frame("t4_inc_sat", 1'b0, 1'b1);
        frame("t4_sat_stop", 1'b0, 1'b0);
        check("t4_refueling_off", 32'(refueling), 32'd0);
        repeat (2) pickup();
        for (int k = 1; k <= 9; k++) frame("t4_inc_to_full", 1'b0, 1'b1);
        frame("t4_full_suppress", 1'b0, 1'b0);
        check("t4_full_refueling_off", 32'(refueling), 32'd0);

        // Pause with 12 pending, pickup while paused, resume for 32 incs.
        drive_fuel(40);
        pickup();
        for (int k = 1; k <= 8; k++) frame("t6_inc_pre", 1'b0, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        check("t6_paused_refueling", 32'(refueling), 32'd0);
        pickup();
        for (int k = 1; k <= 3; k++) frame("t6_paused", 1'b0, 1'b0);
        enable = 1'b1;
        for (int k = 1; k <= 32; k++) frame("t6_inc_resume", 1'b0, 1'b1);
        frame("t6_drained", 1'b0, 1'b0);
        check("t6_refueling_off", 32'(refueling), 32'd0);

        // Low fuel with blink, burning down to empty.
        speed = 2'd3;
        drive_fuel(9);
        @(negedge clk);
        check("t5_low_on", 32'(low_fuel), 32'd1);
        check("t5_warn_start", 32'(warn_blink), 32'd0);
        for (int k = 1; k <= 180; k++) begin
            frame("t5_burn_low", (k % 20) == 0, 1'b0);
            if (k < 180) begin
                check("t5_low", 32'(low_fuel), 32'd1);
                check("t5_blink", 32'(warn_blink), 32'((k / 8) % 2));
            end
        end
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_low_off", 32'(low_fuel), 32'd0);
        check("t5_warn_off", 32'(warn_blink), 32'd0);
        pickup();
        for (int k = 1; k <= 3; k++) frame("t5_empty_pickup", 1'b0, 1'b0);
        check("t5_empty_hold", 32'(empty), 32'd1);
        check("t5_no_refuel", 32'(refueling), 32'd0);

        // Asynchronous reset mid-operation clears the latched empty flag.
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check("reset_async_outs", all_outs(), 32'd0);
        drive_fuel(50);
        @(negedge clk);
        resetN = 1'b1;
        frame("post_reset_burn", 1'b0, 1'b0);
        check("post_reset_empty", 32'(empty), 32'd0);
        check("post_reset_refueling", 32'(refueling), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
